// File: rtl/decode_queue.sv
// Instruction decode queue: up to FETCH_WIDTH MIPS32 instructions are decoded
// and enqueued per cycle, and one decoded entry is presented to the consumer per cycle.
module decode_queue #(
    parameter int FETCH_WIDTH     = 2,
    parameter int DEPTH           = 8,
    parameter int ENABLE_SPECIAL2 = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [FETCH_WIDTH-1:0]        in_valid,
    input  logic [32*FETCH_WIDTH-1:0]     in_instr,
    input  logic [32*FETCH_WIDTH-1:0]     in_pc,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [31:0]                   out_pc,
    output logic [11:0]                   out_ctrl,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Control word: {rw, dst[1:0], imm, mem_rd, mem_wr, mem_to_reg, hilo_wen, is_div, is_mult, ri, sign_ext}
    function automatic logic [11:0] decode(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rw, imm, mr, mw, mtr, hl, dv, ml, ri, se;
        logic [1:0] dst;
        op  = instr[31:26];
        fn  = instr[5:0];
        rs  = instr[25:21];
        rt  = instr[20:16];
        {rw, imm, mr, mw, mtr, hl, dv, ml, ri} = 9'd0;
        dst = 2'b00;
        se  = (op[5:2] != 4'b0011);
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: rw = 1'b1;
                    6'h08, 6'h0C, 6'h0D, 6'h0F: ri = 1'b0;
                    6'h09: begin rw = 1'b1; dst = 2'b10; end
                    6'h11, 6'h13: hl = 1'b1;
                    6'h18, 6'h19: begin hl = 1'b1; ml = 1'b1; end
                    6'h1A, 6'h1B: begin hl = 1'b1; dv = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: ri = 1'b0;
                    5'h10, 5'h11: begin rw = 1'b1; dst = 2'b10; end
                    default: ri = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: ri = 1'b0;
            6'h03: begin rw = 1'b1; dst = 2'b10; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                rw = 1'b1; dst = 2'b01; imm = 1'b1;
            end
            6'h10: begin
                // COP0: MFC0 writes rt; MTC0 and ERET carry no datapath control
                if (rs == 5'h00) begin
                    rw = 1'b1; dst = 2'b01;
                end else if (rs == 5'h04) begin
                    ri = 1'b0;
                end else if ((rs == 5'h10) && (fn == 6'h18)) begin
                    ri = 1'b0;
                end else begin
                    ri = 1'b1;
                end
            end
            6'h1C: begin
                if (ENABLE_SPECIAL2 == 0) begin
                    ri = 1'b1;
                end else begin
                    case (fn)
                        6'h00, 6'h01, 6'h04, 6'h05: begin hl = 1'b1; ml = 1'b1; end
                        6'h02: begin rw = 1'b1; ml = 1'b1; end
                        6'h20, 6'h21: rw = 1'b1;
                        default: ri = 1'b1;
                    endcase
                end
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h30: begin
                rw = 1'b1; dst = 2'b01; imm = 1'b1; mr = 1'b1; mtr = 1'b1;
            end
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
                imm = 1'b1; mw = 1'b1;
            end
            6'h38: begin
                rw = 1'b1; dst = 2'b01; imm = 1'b1; mw = 1'b1; mtr = 1'b1;
            end
            default: ri = 1'b1;
        endcase
        return ri ? {10'd0, 1'b1, se} : {rw, dst, imm, mr, mw, mtr, hl, dv, ml, 1'b0, se};
    endfunction

    logic [31:0]            r_instr_mem [DEPTH];
    logic [31:0]            r_pc_mem    [DEPTH];
    logic [11:0]            r_ctrl_mem  [DEPTH];
    logic [PW-1:0]          r_rptr;
    logic [PW-1:0]          r_wptr;
    logic [CW-1:0]          r_count;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic                   w_pop;
    logic [CW-1:0]          w_npush;
    logic [CW-1:0]          w_count_nxt;
    logic [FETCH_WIDTH-1:0] w_we;
    logic [PW-1:0]          w_slot [FETCH_WIDTH];

    // Compact valid lanes into consecutive slots and compute the next occupancy
    always_comb begin
        w_pop   = r_out_valid & out_ready & ~flush;
        w_npush = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_slot[i] = r_wptr + w_npush[PW-1:0];
            w_we[i]   = r_in_ready & ~flush & in_valid[i];
            w_npush   = w_npush + CW'(w_we[i]);
        end
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + w_npush - CW'(w_pop);
        end
    end

    // Pointers, occupancy and the status flags derived from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (flush) begin
                r_rptr <= '0;
                r_wptr <= '0;
            end else begin
                r_rptr <= r_rptr + PW'(w_pop);
                r_wptr <= r_wptr + w_npush[PW-1:0];
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (CW'(DEPTH) - w_count_nxt) >= CW'(FETCH_WIDTH);
            r_out_valid <= (w_count_nxt != '0);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (w_we[i]) begin
                r_instr_mem[w_slot[i]] <= in_instr[32*i +: 32];
                r_pc_mem[w_slot[i]]    <= in_pc[32*i +: 32];
                r_ctrl_mem[w_slot[i]]  <= decode(in_instr[32*i +: 32]);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign out_instr = r_out_valid ? r_instr_mem[r_rptr] : 32'd0;
    assign out_pc    = r_out_valid ? r_pc_mem[r_rptr]    : 32'd0;
    assign out_ctrl  = r_out_valid ? r_ctrl_mem[r_rptr]  : 12'd0;

endmodule
